// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network layer datapath.
// Holds the serializer state encoding and the default layer dimensions.
package nn_pkg;

  localparam int NN_DEFAULT         = 30;
  localparam int DATA_WIDTH_DEFAULT = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/layer_output_serializer.sv
// Captures one parallel vector of neuron outputs and streams it word by word
// to the next layer, with ready/valid backpressure and sticky error flags.
module layer_output_serializer
  import nn_pkg::*;
#(
  parameter int NN        = NN_DEFAULT,
  parameter int dataWidth = DATA_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NN-1:0]             i_valid,
  input  logic [NN*dataWidth-1:0]   i_data,
  input  logic                      o_ready,
  output logic                      o_valid,
  output logic [dataWidth-1:0]      o_data,
  output logic                      o_last,
  output logic                      busy,
  output logic                      err_overrun,
  output logic                      err_partial
);

  localparam int              IdxW    = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NN - 1);

  state_t               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [dataWidth-1:0] buf_q [NN];
  logic [dataWidth-1:0] buf_d [NN];
  logic                 o_valid_q, o_valid_d;
  logic [dataWidth-1:0] o_data_q, o_data_d;
  logic                 o_last_q, o_last_d;
  logic                 overrun_q, overrun_d;
  logic                 partial_q, partial_d;
  logic                 trigger;
  logic                 xfer;
  logic                 capture;

  // A new vector is accepted when idle, or exactly as the final word leaves.
  always_comb begin
    trigger   = i_valid[0];
    xfer      = (state_q == SHIFT) && o_ready;
    capture   = trigger && ((state_q == IDLE) || (xfer && (idx_q == LastIdx)));
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    overrun_d = overrun_q;
    partial_d = partial_q;

    if (capture) begin
      for (int k = 0; k < NN; k++) begin
        buf_d[k] = i_data[k*dataWidth +: dataWidth];
      end
      idx_d   = '0;
      state_d = SHIFT;
      if (i_valid != '1) begin
        partial_d = 1'b1;
      end
    end else begin
      if (trigger) begin
        overrun_d = 1'b1;
      end
      if (xfer) begin
        if (idx_q == LastIdx) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end

    // Outputs are registered from next-state so they line up with state_q.
    o_valid_d = (state_d == SHIFT);
    o_last_d  = (state_d == SHIFT) && (idx_d == LastIdx);
    o_data_d  = o_valid_d ? buf_d[idx_d] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      for (int k = 0; k < NN; k++) begin
        buf_q[k] <= '0;
      end
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      overrun_q <= 1'b0;
      partial_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      overrun_q <= overrun_d;
      partial_q <= partial_d;
    end
  end

  assign o_valid     = o_valid_q;
  assign o_data      = o_data_q;
  assign o_last      = o_last_q;
  assign busy        = o_valid_q;
  assign err_overrun = overrun_q;
  assign err_partial = partial_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Self-checking bench for layer_output_serializer (NN=4, dataWidth=16),
// compared against a words-remaining reference model of the serializer.
module tb_layer_output_serializer;

  localparam int NN = 4;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NN-1:0]    i_valid = '0;
  logic [NN*DW-1:0] i_data = '0;
  logic             o_ready = 1'b0;
  logic             o_valid;
  logic [DW-1:0]    o_data;
  logic             o_last;
  logic             busy;
  logic             err_overrun;
  logic             err_partial;

  int checks = 0;
  int errors = 0;

  // Reference model: the vector being sent and how many words are still owed.
  logic [DW-1:0] m_vec [NN];
  int            m_rem = 0;
  bit            m_overrun = 1'b0;
  bit            m_partial = 1'b0;
  logic [DW-1:0] got [$];

  layer_output_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .busy(busy),
    .err_overrun(err_overrun), .err_partial(err_partial)
  );

  always #5 clk = ~clk;

  function automatic logic exp_valid();
    return m_rem > 0;
  endfunction

  function automatic logic [DW-1:0] exp_data();
    return (m_rem > 0) ? m_vec[NN-m_rem] : '0;
  endfunction

  function automatic logic exp_last();
    return m_rem == 1;
  endfunction

  function automatic logic [NN*DW-1:0] pack4(input logic [DW-1:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic model_clear();
    m_rem = 0;
    m_overrun = 1'b0;
    m_partial = 1'b0;
    got.delete();
  endtask

  // Called at a falling edge; applies inputs for the next rising edge.
  task automatic drive_cycle(input logic [NN-1:0] iv, input logic [NN*DW-1:0] data, input logic rdy);
    bit xfer;
    i_valid = iv;
    i_data  = data;
    o_ready = rdy;
    if (o_valid && rdy) got.push_back(o_data);
    xfer = (m_rem > 0) && rdy;
    if (iv[0] && (m_rem == 0 || (m_rem == 1 && xfer))) begin
      for (int k = 0; k < NN; k++) m_vec[k] = data[k*DW +: DW];
      m_rem = NN;
      if (iv != '1) m_partial = 1'b1;
    end else begin
      if (iv[0]) m_overrun = 1'b1;
      if (xfer) m_rem--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_valid = '0;
    i_data = '0;
    o_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_valid: got %0h expected 0", o_valid); end
    checks++; if (o_data !== '0) begin errors++; $display("[TB] FAIL reset_o_data: got %0h expected 0", o_data); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_o_last: got %0h expected 0", o_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_overrun: got %0h expected 0", err_overrun); end
    checks++; if (err_partial !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_partial: got %0h expected 0", err_partial); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    drive_cycle(4'hF, pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004), 1'b1);
    for (int c = 0; c < 5; c++) begin
      checks++; if (o_valid !== exp_valid()) begin errors++; $display("[TB] FAIL single_valid c%0d: got %0h expected %0h", c, o_valid, exp_valid()); end
      checks++; if (o_data !== exp_data()) begin errors++; $display("[TB] FAIL single_data c%0d: got %0h expected %0h", c, o_data, exp_data()); end
      checks++; if (o_last !== exp_last()) begin errors++; $display("[TB] FAIL single_last c%0d: got %0h expected %0h", c, o_last, exp_last()); end
      checks++; if (busy !== exp_valid()) begin errors++; $display("[TB] FAIL single_busy c%0d: got %0h expected %0h", c, busy, exp_valid()); end
      if (c < 4) drive_cycle(4'h0, '0, 1'b1);
    end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("[TB] FAIL single_count: got %0d expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (got[i] !== DW'(i + 1)) begin errors++; $display("[TB] FAIL single_order w%0d: got %0h expected %0h", i, got[i], i + 1); end
    end
  endtask

  task automatic test_backpressure();
    bit rdy_seq [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    drive_cycle(4'hF, pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004), 1'b1);
    for (int c = 0; c < 7; c++) begin
      checks++; if (o_valid !== exp_valid()) begin errors++; $display("[TB] FAIL bp_valid c%0d: got %0h expected %0h", c, o_valid, exp_valid()); end
      checks++; if (o_data !== exp_data()) begin errors++; $display("[TB] FAIL bp_data c%0d: got %0h expected %0h", c, o_data, exp_data()); end
      if (c == 1 || c == 2) begin
        checks++; if (o_data !== 16'h0002) begin errors++; $display("[TB] FAIL bp_hold c%0d: got %0h expected 2", c, o_data); end
      end
      drive_cycle(4'h0, '0, rdy_seq[c]);
    end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle: got %0h expected 0", o_valid); end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("[TB] FAIL bp_count: got %0d expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (got[i] !== DW'(i + 1)) begin errors++; $display("[TB] FAIL bp_order w%0d: got %0h expected %0h", i, got[i], i + 1); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_cycle(4'hF, pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004), 1'b1);
    for (int c = 0; c < 8; c++) begin
      checks++; if (o_valid !== exp_valid()) begin errors++; $display("[TB] FAIL b2b_valid c%0d: got %0h expected %0h", c, o_valid, exp_valid()); end
      checks++; if (o_data !== exp_data()) begin errors++; $display("[TB] FAIL b2b_data c%0d: got %0h expected %0h", c, o_data, exp_data()); end
      if (c == 4) begin
        checks++; if (o_valid !== 1'b1 || o_data !== 16'h0005) begin errors++; $display("[TB] FAIL b2b_nogap: got v%0h d%0h expected v1 d5", o_valid, o_data); end
      end
      if (c == 3) drive_cycle(4'hF, pack4(16'h0005, 16'h0006, 16'h0007, 16'h0008), 1'b1);
      else        drive_cycle(4'h0, '0, 1'b1);
    end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got %0h expected 0", o_valid); end
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun: got %0h expected 0", err_overrun); end
    checks++;
    if (got.size() != 8) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d expected 8", got.size());
    end else begin
      for (int i = 0; i < 8; i++)
        if (got[i] !== DW'(i + 1)) begin errors++; $display("[TB] FAIL b2b_order w%0d: got %0h expected %0h", i, got[i], i + 1); end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    drive_cycle(4'hF, pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004), 1'b1);
    for (int c = 0; c < 5; c++) begin
      checks++; if (o_data !== exp_data()) begin errors++; $display("[TB] FAIL ovr_data c%0d: got %0h expected %0h", c, o_data, exp_data()); end
      if (c == 1) drive_cycle(4'hF, pack4(16'h0099, 16'h0099, 16'h0099, 16'h0099), 1'b1);
      else        drive_cycle(4'h0, '0, 1'b1);
    end
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag: got %0h expected 1", err_overrun); end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("[TB] FAIL ovr_count: got %0d expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (got[i] !== DW'(i + 1)) begin errors++; $display("[TB] FAIL ovr_order w%0d: got %0h expected %0h", i, got[i], i + 1); end
    end
    repeat (3) drive_cycle(4'h0, '0, 1'b1);
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky: got %0h expected 1", err_overrun); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_idle: got %0h expected 0", o_valid); end
  endtask

  task automatic test_partial_reset();
    do_reset();
    drive_cycle(4'h1, pack4(16'h0011, 16'h0022, 16'h0033, 16'h0044), 1'b1);
    checks++; if (err_partial !== 1'b1) begin errors++; $display("[TB] FAIL part_flag: got %0h expected 1", err_partial); end
    checks++; if (o_valid !== 1'b1 || o_data !== 16'h0011) begin errors++; $display("[TB] FAIL part_word0: got v%0h d%0h expected v1 d11", o_valid, o_data); end
    drive_cycle(4'h0, '0, 1'b1);
    checks++; if (o_data !== 16'h0022) begin errors++; $display("[TB] FAIL part_word1: got %0h expected 22", o_data); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid: got %0h expected 0", o_valid); end
    checks++; if (o_data !== '0) begin errors++; $display("[TB] FAIL rstmid_data: got %0h expected 0", o_data); end
    checks++; if (o_last !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_last_busy: got l%0h b%0h expected 0 0", o_last, busy); end
    checks++; if (err_partial !== 1'b0 || err_overrun !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_flags: got p%0h o%0h expected 0 0", err_partial, err_overrun); end
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) drive_cycle(4'h0, '0, 1'b1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_nowords: got %0h expected 0", o_valid); end
    drive_cycle(4'hF, pack4(16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4), 1'b1);
    checks++; if (o_valid !== 1'b1 || o_data !== 16'h00A1) begin errors++; $display("[TB] FAIL rstmid_resume: got v%0h d%0h expected v1 dA1", o_valid, o_data); end
  endtask

  task automatic test_random();
    logic [NN-1:0]    iv;
    logic [NN*DW-1:0] data;
    logic             rdy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      checks++; if (o_valid !== exp_valid()) begin errors++; $display("[TB] FAIL rnd_valid c%0d: got %0h expected %0h", c, o_valid, exp_valid()); end
      checks++; if (o_data !== exp_data()) begin errors++; $display("[TB] FAIL rnd_data c%0d: got %0h expected %0h", c, o_data, exp_data()); end
      checks++; if (o_last !== exp_last()) begin errors++; $display("[TB] FAIL rnd_last c%0d: got %0h expected %0h", c, o_last, exp_last()); end
      checks++; if (busy !== exp_valid()) begin errors++; $display("[TB] FAIL rnd_busy c%0d: got %0h expected %0h", c, busy, exp_valid()); end
      checks++; if (err_overrun !== m_overrun) begin errors++; $display("[TB] FAIL rnd_overrun c%0d: got %0h expected %0h", c, err_overrun, m_overrun); end
      checks++; if (err_partial !== m_partial) begin errors++; $display("[TB] FAIL rnd_partial c%0d: got %0h expected %0h", c, err_partial, m_partial); end
      iv[0] = ($urandom_range(0, 5) == 0) || (m_rem == 1 && $urandom_range(0, 1) == 1);
      iv[NN-1:1] = ($urandom_range(0, 7) == 0) ? (NN-1)'($urandom) : '1;
      data = {$urandom, $urandom};
      rdy = ($urandom_range(0, 3) != 0);
      drive_cycle(iv, data, rdy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_partial_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
